gate_tester: RTL and testbench



---
 rtl/gate_tester.sv | 108 ++++++++++
 tb/tb_gate_tester.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_tester.sv
// Self-test sequencer for a 2-input gate: drives the four A/B vectors, waits
// SETTLE cycles per vector, checks X against TRUTH and reports per-vector fails.
module gate_tester #(
  parameter logic [3:0]  TRUTH        = 4'b0111,
  parameter int unsigned SETTLE       = 2,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       X,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_VEC,
  output logic [1:0] VEC_IDX
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("gate_tester: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_q, fail_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       mism;
  logic       sample;
  logic [1:0] idx_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      fail_q  <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_nxt = idx_q + 2'd1;
    // Case inequality so an X/Z from the gate in simulation is a mismatch.
    mism    = (X !== TRUTH[idx_q]);
    sample  = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_APPLY;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          fail_d  = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
      end
      S_APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (sample) begin
          fail_d = fail_q | ({3'b000, mism} << idx_q);
          cnt_d  = 4'd0;
          if (idx_q == 2'd3 || (STOP_ON_FAIL && mism)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_nxt;
            a_d   = idx_nxt[0];
            b_d   = idx_nxt[1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A        = a_q;
  assign B        = b_q;
  assign VEC_IDX  = idx_q;
  assign FAIL_VEC = fail_q;
  assign BUSY     = (state_q == S_APPLY);
  assign DONE     = (state_q == S_DONE);
  assign PASS     = (state_q == S_DONE) && (fail_q == 4'd0);

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: a cycle table on a NAND checker plus short
// sequences on instances with other gates, parameters and fault models.
module tb_gate_tester;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] start_v = 6'd0;
  logic       frc_en = 1'b0;
  logic       frc_val = 1'b0;

  wire  [5:0] x_v, a_v, b_v, busy_v, done_v, pass_v;
  wire  [3:0] fv_v [6];
  wire  [1:0] idx_v [6];

  logic [2:0] d4, d5;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  // 0: NAND with optional forced X; 1: NAND stuck at 0 for A=1,B=0;
  // 2,3: AND gate; 4,5: NAND with 3-cycle registered output.
  assign x_v[0] = frc_en ? frc_val : ~(a_v[0] & b_v[0]);
  assign x_v[1] = ~(a_v[1] & b_v[1]) & ~(a_v[1] & ~b_v[1]);
  assign x_v[2] = a_v[2] & b_v[2];
  assign x_v[3] = a_v[3] & b_v[3];
  assign x_v[4] = d4[2];
  assign x_v[5] = d5[2];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d4 <= 3'd0;
      d5 <= 3'd0;
    end else begin
      d4 <= {d4[1:0], ~(a_v[4] & b_v[4])};
      d5 <= {d5[1:0], ~(a_v[5] & b_v[5])};
    end
  end

  gate_tester #(.TRUTH(4'b0111), .SETTLE(2), .STOP_ON_FAIL(1'b0)) u0 (
    .CLK(CLK), .RST(RST), .START(start_v[0]), .X(x_v[0]), .A(a_v[0]), .B(b_v[0]),
    .BUSY(busy_v[0]), .DONE(done_v[0]), .PASS(pass_v[0]), .FAIL_VEC(fv_v[0]), .VEC_IDX(idx_v[0]));
  gate_tester #(.TRUTH(4'b0111), .SETTLE(2), .STOP_ON_FAIL(1'b1)) u1 (
    .CLK(CLK), .RST(RST), .START(start_v[1]), .X(x_v[1]), .A(a_v[1]), .B(b_v[1]),
    .BUSY(busy_v[1]), .DONE(done_v[1]), .PASS(pass_v[1]), .FAIL_VEC(fv_v[1]), .VEC_IDX(idx_v[1]));
  gate_tester u2 (
    .CLK(CLK), .RST(RST), .START(start_v[2]), .X(x_v[2]), .A(a_v[2]), .B(b_v[2]),
    .BUSY(busy_v[2]), .DONE(done_v[2]), .PASS(pass_v[2]), .FAIL_VEC(fv_v[2]), .VEC_IDX(idx_v[2]));
  gate_tester #(.TRUTH(4'b1000), .SETTLE(2), .STOP_ON_FAIL(1'b0)) u3 (
    .CLK(CLK), .RST(RST), .START(start_v[3]), .X(x_v[3]), .A(a_v[3]), .B(b_v[3]),
    .BUSY(busy_v[3]), .DONE(done_v[3]), .PASS(pass_v[3]), .FAIL_VEC(fv_v[3]), .VEC_IDX(idx_v[3]));
  gate_tester #(.TRUTH(4'b0111), .SETTLE(1), .STOP_ON_FAIL(1'b0)) u4 (
    .CLK(CLK), .RST(RST), .START(start_v[4]), .X(x_v[4]), .A(a_v[4]), .B(b_v[4]),
    .BUSY(busy_v[4]), .DONE(done_v[4]), .PASS(pass_v[4]), .FAIL_VEC(fv_v[4]), .VEC_IDX(idx_v[4]));
  gate_tester #(.TRUTH(4'b0111), .SETTLE(5), .STOP_ON_FAIL(1'b0)) u5 (
    .CLK(CLK), .RST(RST), .START(start_v[5]), .X(x_v[5]), .A(a_v[5]), .B(b_v[5]),
    .BUSY(busy_v[5]), .DONE(done_v[5]), .PASS(pass_v[5]), .FAIL_VEC(fv_v[5]), .VEC_IDX(idx_v[5]));

  // exp packs {A, B, BUSY, DONE, PASS, FAIL_VEC[3:0], VEC_IDX[1:0]} after the edge.
  typedef struct {
    bit          start;
    bit          fen;
    bit          fval;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, bit fe, bit fvl, bit a, bit b, bit busy, bit done,
                              bit pass, logic [3:0] fv, logic [1:0] idx);
    vec_t v;
    v.start = s;
    v.fen   = fe;
    v.fval  = fvl;
    v.exp   = {a, b, busy, done, pass, fv, idx};
    return v;
  endfunction

  function automatic logic [10:0] outs(int i);
    return {a_v[i], b_v[i], busy_v[i], done_v[i], pass_v[i], fv_v[i], idx_v[i]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, got, exp);
    end
  endtask

  task automatic run_inst(input int i, output int nbusy);
    start_v[i] = 1'b1;
    @(posedge CLK); #1;
    start_v[i] = 1'b0;
    nbusy = 0;
    for (int c = 0; c < 200; c++) begin
      if (done_v[i]) break;
      if (busy_v[i]) nbusy++;
      @(posedge CLK); #1;
    end
    chk($sformatf("u%0d_done_reached", i), 32'(done_v[i]), 32'd1);
  endtask

  initial begin
    int nb;

    // Run 1: clean NAND run from IDLE.
    tbl.push_back(mk(1,0,0, 0,0,1,0,0, 4'b0000, 2'd0));
    tbl.push_back(mk(0,0,0, 0,0,1,0,0, 4'b0000, 2'd0));
    tbl.push_back(mk(0,0,0, 1,0,1,0,0, 4'b0000, 2'd1));
    tbl.push_back(mk(0,0,0, 1,0,1,0,0, 4'b0000, 2'd1));
    tbl.push_back(mk(0,0,0, 0,1,1,0,0, 4'b0000, 2'd2));
    tbl.push_back(mk(0,0,0, 0,1,1,0,0, 4'b0000, 2'd2));
    tbl.push_back(mk(0,0,0, 1,1,1,0,0, 4'b0000, 2'd3));
    tbl.push_back(mk(0,0,0, 1,1,1,0,0, 4'b0000, 2'd3));
    tbl.push_back(mk(0,0,0, 1,1,0,1,1, 4'b0000, 2'd3));
    tbl.push_back(mk(0,0,0, 1,1,0,1,1, 4'b0000, 2'd3));
    // Run 2: restart from DONE, X forced to 1 during vector 3.
    tbl.push_back(mk(1,0,0, 0,0,1,0,0, 4'b0000, 2'd0));
    tbl.push_back(mk(0,0,0, 0,0,1,0,0, 4'b0000, 2'd0));
    tbl.push_back(mk(0,0,0, 1,0,1,0,0, 4'b0000, 2'd1));
    tbl.push_back(mk(0,0,0, 1,0,1,0,0, 4'b0000, 2'd1));
    tbl.push_back(mk(0,0,0, 0,1,1,0,0, 4'b0000, 2'd2));
    tbl.push_back(mk(0,0,0, 0,1,1,0,0, 4'b0000, 2'd2));
    tbl.push_back(mk(0,0,0, 1,1,1,0,0, 4'b0000, 2'd3));
    tbl.push_back(mk(0,1,1, 1,1,1,0,0, 4'b0000, 2'd3));
    tbl.push_back(mk(0,1,1, 1,1,0,1,0, 4'b1000, 2'd3));
    tbl.push_back(mk(0,0,0, 1,1,0,1,0, 4'b1000, 2'd3));
    // Run 3: restart clears FAIL_VEC; START during cycle 3 is ignored.
    tbl.push_back(mk(1,0,0, 0,0,1,0,0, 4'b0000, 2'd0));
    tbl.push_back(mk(0,0,0, 0,0,1,0,0, 4'b0000, 2'd0));
    tbl.push_back(mk(1,0,0, 1,0,1,0,0, 4'b0000, 2'd1));
    tbl.push_back(mk(0,0,0, 1,0,1,0,0, 4'b0000, 2'd1));
    tbl.push_back(mk(0,0,0, 0,1,1,0,0, 4'b0000, 2'd2));
    tbl.push_back(mk(0,0,0, 0,1,1,0,0, 4'b0000, 2'd2));
    tbl.push_back(mk(0,0,0, 1,1,1,0,0, 4'b0000, 2'd3));
    tbl.push_back(mk(0,0,0, 1,1,1,0,0, 4'b0000, 2'd3));
    tbl.push_back(mk(0,0,0, 1,1,0,1,1, 4'b0000, 2'd3));
    tbl.push_back(mk(0,0,0, 1,1,0,1,1, 4'b0000, 2'd3));

    #12;
    for (int i = 0; i < 6; i++) chk($sformatf("reset_u%0d", i), 32'(outs(i)), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("idle_no_autostart", 32'(outs(0)), 32'd0);

    foreach (tbl[i]) begin
      start_v[0] = tbl[i].start;
      frc_en     = tbl[i].fen;
      frc_val    = tbl[i].fval;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d", i), 32'(outs(0)), 32'(tbl[i].exp));
    end
    start_v[0] = 1'b0;
    frc_en     = 1'b0;

    // STOP_ON_FAIL: gate wrong on vector 1 ends the run after 4 BUSY cycles.
    run_inst(1, nb);
    chk("stop_busy_cycles", 32'(nb), 32'd4);
    chk("stop_outs", 32'(outs(1)), 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1}));

    run_inst(2, nb);
    chk("and_default_truth", 32'({pass_v[2], fv_v[2]}), 32'({1'b0, 4'b1111}));
    chk("and_default_busy", 32'(nb), 32'd8);

    run_inst(3, nb);
    chk("and_truth_1000", 32'({pass_v[3], fv_v[3]}), 32'({1'b1, 4'b0000}));

    // START held high: runs back to back, restarting on the first DONE cycle.
    start_v[3] = 1'b1;
    @(posedge CLK); #1;
    chk("held_start_run", 32'({busy_v[3], done_v[3]}), 32'b10);
    for (int c = 0; c < 50; c++) begin
      if (done_v[3]) break;
      @(posedge CLK); #1;
    end
    chk("held_start_done", 32'(done_v[3]), 32'd1);
    @(posedge CLK); #1;
    chk("held_start_restart", 32'({busy_v[3], done_v[3], fv_v[3]}), 32'({1'b1, 1'b0, 4'b0000}));
    start_v[3] = 1'b0;

    run_inst(4, nb);
    chk("settle1_slow_gate", 32'({pass_v[4], fv_v[4]}), 32'({1'b0, 4'b1000}));

    run_inst(5, nb);
    chk("settle5_pass", 32'({pass_v[5], fv_v[5]}), 32'({1'b1, 4'b0000}));
    chk("settle5_busy", 32'(nb), 32'd20);

    // Asynchronous reset during vector 2, then a clean rerun.
    start_v[0] = 1'b1;
    @(posedge CLK); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("pre_reset_vec2", 32'({busy_v[0], idx_v[0]}), 32'({1'b1, 2'd2}));
    #2;
    RST = 1'b1;
    #1;
    chk("async_reset_outs", 32'(outs(0)), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_reset_idle", 32'(outs(0)), 32'd0);
    run_inst(0, nb);
    chk("rerun_busy", 32'(nb), 32'd8);
    chk("rerun_result", 32'({pass_v[0], fv_v[0]}), 32'({1'b1, 4'b0000}));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
